id_hazard_sequencer: RTL and testbench

ID_HAZARD_SEQUENCER -- requirements
Module: id_hazard_sequencer

---
 rtl/hazard_pkg.sv | 17 +
 rtl/id_hazard_sequencer_if.sv | 36 +++
 rtl/hazard_detect.sv | 29 ++
 rtl/id_hazard_sequencer.sv | 104 ++++++++++
 tb/tb_id_hazard_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - state encoding and stall-length constants for the ID hazard sequencer
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam int DRAIN_CYCLES_DEF = 4;

  localparam logic [1:0] LEN_NONE = 2'd0;
  localparam logic [1:0] LEN_ONE  = 2'd1;
  localparam logic [1:0] LEN_TWO  = 2'd2;

endpackage

// File: rtl/id_hazard_sequencer_if.sv
// rtl/id_hazard_sequencer_if.sv - pipeline-status inputs and stall/flush controls of the sequencer
interface id_hazard_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             i_enable;
  logic             i_IDEX_MemRead;
  logic             i_IDEX_RegWrite;
  logic [4:0]       i_IDEX_Rd;
  logic [4:0]       i_IFID_Rs;
  logic [4:0]       i_IFID_Rt;
  logic             i_IFID_UsesRt;
  logic             i_IFID_Branch;
  logic             i_Jump;
  logic             i_BranchTaken;
  logic             i_HALT;
  logic             o_Risk;
  logic             o_PC_Write;
  logic             o_IFID_Write;
  logic             o_IFID_Flush;
  logic             o_Halted;
  logic [1:0]       o_State;
  logic [CNT_W-1:0] o_StallCount;

  modport master (
    output i_enable, i_IDEX_MemRead, i_IDEX_RegWrite, i_IDEX_Rd, i_IFID_Rs, i_IFID_Rt,
           i_IFID_UsesRt, i_IFID_Branch, i_Jump, i_BranchTaken, i_HALT,
    input  o_Risk, o_PC_Write, o_IFID_Write, o_IFID_Flush, o_Halted, o_State, o_StallCount
  );

  modport slave (
    input  i_enable, i_IDEX_MemRead, i_IDEX_RegWrite, i_IDEX_Rd, i_IFID_Rs, i_IFID_Rt,
           i_IFID_UsesRt, i_IFID_Branch, i_Jump, i_BranchTaken, i_HALT,
    output o_Risk, o_PC_Write, o_IFID_Write, o_IFID_Flush, o_Halted, o_State, o_StallCount
  );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational source match and bubble-length decision for the ID stage
module hazard_detect
  import hazard_pkg::*;
(
  input  logic       i_mem_read,
  input  logic       i_reg_write,
  input  logic [4:0] i_rd,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic       i_uses_rt,
  input  logic       i_branch,
  output logic [1:0] o_len
);

  logic src_match;

  assign src_match = (i_rd != 5'd0) && ((i_rd == i_rs) || (i_uses_rt && (i_rd == i_rt)));

  // A load feeding a branch needs one extra bubble since branches resolve in ID.
  always_comb begin
    o_len = LEN_NONE;
    if (src_match && i_mem_read) begin
      o_len = i_branch ? LEN_TWO : LEN_ONE;
    end else if (src_match && i_branch && i_reg_write) begin
      o_len = LEN_ONE;
    end
  end

endmodule

// File: rtl/id_hazard_sequencer.sv
// rtl/id_hazard_sequencer.sv - ID-stage stall/flush/halt sequencer with saturating bubble counter
module id_hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  id_hazard_sequencer_if.slave  bus
);

  localparam int CW = $clog2(DRAIN_CYCLES);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [1:0]       len;
  logic             risk, pc_write, ifid_write, ifid_flush;

  hazard_detect u_hazard_detect (
    .i_mem_read  (bus.i_IDEX_MemRead),
    .i_reg_write (bus.i_IDEX_RegWrite),
    .i_rd        (bus.i_IDEX_Rd),
    .i_rs        (bus.i_IFID_Rs),
    .i_rt        (bus.i_IFID_Rt),
    .i_uses_rt   (bus.i_IFID_UsesRt),
    .i_branch    (bus.i_IFID_Branch),
    .o_len       (len)
  );

  // Controls are Mealy so a hazard bubbles the very cycle it appears; reset forces a bubble.
  always_comb begin
    risk       = 1'b0;
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    if (!i_rst_n) begin
      risk = 1'b1;
    end else if (bus.i_enable) begin
      if (state_q != ST_RUN) begin
        risk = 1'b1;
      end else if (len != LEN_NONE) begin
        risk = 1'b1;
      end else if (!bus.i_HALT) begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = bus.i_Jump | bus.i_BranchTaken;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.i_enable) begin
      case (state_q)
        ST_RUN: begin
          if (len == LEN_TWO) begin
            state_d = ST_STALL;
            cnt_d   = CW'(1);
          end else if (len == LEN_NONE && bus.i_HALT) begin
            state_d = ST_DRAIN;
            cnt_d   = CW'(DRAIN_CYCLES - 1);
          end
        end
        ST_STALL, ST_DRAIN: begin
          if (cnt_q <= CW'(1)) begin
            state_d = (state_q == ST_STALL) ? ST_RUN : ST_HALTED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
      if (risk && (state_q == ST_RUN || state_q == ST_STALL) && stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_Risk       = risk;
  assign bus.o_PC_Write   = pc_write;
  assign bus.o_IFID_Write = ifid_write;
  assign bus.o_IFID_Flush = ifid_flush;
  assign bus.o_Halted     = (state_q == ST_HALTED);
  assign bus.o_State      = state_q;
  assign bus.o_StallCount = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_sequencer.sv
// tb/tb_id_hazard_sequencer.sv - directed bench with per-cycle reference model for id_hazard_sequencer
module tb_id_hazard_sequencer;

  localparam int DC   = 4;
  localparam int CW_S = 4;
  localparam int SAT  = (1 << CW_S) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_hazard_sequencer_if #(.CNT_W(CW_S)) bus ();

  id_hazard_sequencer #(.DRAIN_CYCLES(DC), .CNT_W(CW_S)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: remaining frozen cycles after the current one, and what kind of freeze it is.
  int m_rem     = 0;
  bit m_drain   = 1'b0;
  bit m_halted  = 1'b0;
  int m_count   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bubbles_needed();
    int  rd;
    bit  dep;
    rd  = int'(bus.i_IDEX_Rd);
    dep = (rd != 0) && (rd == int'(bus.i_IFID_Rs) ||
                        (bus.i_IFID_UsesRt && rd == int'(bus.i_IFID_Rt)));
    if (!dep) return 0;
    if (bus.i_IDEX_MemRead) return bus.i_IFID_Branch ? 2 : 1;
    if (bus.i_IFID_Branch && bus.i_IDEX_RegWrite) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem = 0; m_drain = 1'b0; m_halted = 1'b0; m_count = 0;
    end else if (bus.i_enable && !m_halted) begin
      if (m_rem > 0) begin
        if (!m_drain && m_count < SAT) m_count++;
        m_rem--;
        if (m_rem == 0 && m_drain) m_halted = 1'b1;
      end else if (bubbles_needed() > 0) begin
        if (m_count < SAT) m_count++;
        m_rem   = bubbles_needed() - 1;
        m_drain = 1'b0;
      end else if (bus.i_HALT) begin
        m_rem   = DC - 1;
        m_drain = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit e_risk, e_pcw, e_ifw, e_flush, e_halted;
    int e_state;
    e_risk = 0; e_pcw = 0; e_ifw = 0; e_flush = 0;
    e_halted = m_halted && rst_n;
    e_state  = !rst_n ? 0 : m_halted ? 3 : (m_rem > 0) ? (m_drain ? 2 : 1) : 0;
    if (!rst_n) begin
      e_risk = 1;
    end else if (bus.i_enable) begin
      if (e_state != 0)                e_risk = 1;
      else if (bubbles_needed() > 0)   e_risk = 1;
      else if (!bus.i_HALT) begin
        e_pcw = 1; e_ifw = 1; e_flush = bus.i_Jump | bus.i_BranchTaken;
      end
    end
    chk("m_risk",   32'(bus.o_Risk),       32'(e_risk));
    chk("m_pcw",    32'(bus.o_PC_Write),   32'(e_pcw));
    chk("m_ifw",    32'(bus.o_IFID_Write), 32'(e_ifw));
    chk("m_flush",  32'(bus.o_IFID_Flush), 32'(e_flush));
    chk("m_halted", 32'(bus.o_Halted),     32'(e_halted));
    chk("m_state",  32'(bus.o_State),      32'(e_state));
    chk("m_count",  32'(bus.o_StallCount), 32'(m_count));
  end

  task automatic cyc(input bit r, input bit en, input bit mr, input bit rw,
                     input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                     input bit ut, input bit br, input bit jp, input bit bt, input bit ht);
    @(posedge clk);
    #1;
    rst_n                = r;
    bus.i_enable         = en;
    bus.i_IDEX_MemRead   = mr;
    bus.i_IDEX_RegWrite  = rw;
    bus.i_IDEX_Rd        = rd;
    bus.i_IFID_Rs        = rs;
    bus.i_IFID_Rt        = rt;
    bus.i_IFID_UsesRt    = ut;
    bus.i_IFID_Branch    = br;
    bus.i_Jump           = jp;
    bus.i_BranchTaken    = bt;
    bus.i_HALT           = ht;
    #2;
  endtask

  task automatic idle();
    cyc(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.i_enable = 1'b1; bus.i_IDEX_MemRead = 1'b0; bus.i_IDEX_RegWrite = 1'b0;
    bus.i_IDEX_Rd = '0; bus.i_IFID_Rs = '0; bus.i_IFID_Rt = '0; bus.i_IFID_UsesRt = 1'b0;
    bus.i_IFID_Branch = 1'b0; bus.i_Jump = 1'b0; bus.i_BranchTaken = 1'b0; bus.i_HALT = 1'b0;

    cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    chk("rst_risk", 32'(bus.o_Risk), 1);
    chk("rst_pcw",  32'(bus.o_PC_Write), 0);
    chk("rst_cnt",  32'(bus.o_StallCount), 0);

    idle();
    chk("run_pcw", 32'(bus.o_PC_Write), 1);

    // lw $2 in EX, add $3,$2,$4 in ID
    cyc(1, 1, 1, 1, 5'd2, 5'd2, 5'd4, 1, 0, 0, 0, 0);
    chk("lu_risk", 32'(bus.o_Risk), 1);
    chk("lu_pcw",  32'(bus.o_PC_Write), 0);
    idle();
    chk("lu_cnt", 32'(bus.o_StallCount), 1);

    // lw $2 in EX, beq $2,$5 in ID: two bubbles
    cyc(1, 1, 1, 1, 5'd2, 5'd2, 5'd5, 1, 1, 0, 0, 0);
    chk("lb_state0", 32'(bus.o_State), 0);
    cyc(1, 1, 0, 0, 5'd0, 5'd2, 5'd5, 1, 1, 0, 0, 0);
    chk("lb_state1", 32'(bus.o_State), 1);
    chk("lb_risk1",  32'(bus.o_Risk), 1);
    cyc(1, 1, 0, 0, 5'd0, 5'd2, 5'd5, 1, 1, 0, 0, 0);
    chk("lb_state2", 32'(bus.o_State), 0);
    chk("lb_cnt",    32'(bus.o_StallCount), 3);

    // rd=0 load never stalls; taken branch flushes one cycle
    cyc(1, 1, 1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0);
    chk("r0_risk", 32'(bus.o_Risk), 0);
    cyc(1, 1, 0, 0, 5'd0, 5'd3, 5'd5, 1, 1, 0, 1, 0);
    chk("bt_flush", 32'(bus.o_IFID_Flush), 1);
    idle();
    chk("bt_flush_off", 32'(bus.o_IFID_Flush), 0);

    // ALU result feeding a branch; rt ignored when not used; hazard beats jump
    cyc(1, 1, 0, 1, 5'd7, 5'd1, 5'd7, 1, 1, 0, 0, 0);
    chk("ab_risk", 32'(bus.o_Risk), 1);
    cyc(1, 1, 1, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 1, 0, 0);
    chk("hj_flush", 32'(bus.o_IFID_Flush), 0);
    cyc(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    chk("jp_flush", 32'(bus.o_IFID_Flush), 1);

    // freeze in the middle of a two-cycle stall
    cyc(1, 1, 1, 1, 5'd6, 5'd6, 5'd0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 5'd0, 5'd6, 5'd0, 0, 1, 0, 0, 0);
    chk("fz_state", 32'(bus.o_State), 1);
    chk("fz_cnt",   32'(bus.o_StallCount), 6);
    cyc(1, 1, 0, 0, 5'd0, 5'd6, 5'd0, 0, 1, 0, 0, 0);
    chk("fz_resume_risk", 32'(bus.o_Risk), 1);
    idle();
    chk("fz_done_state", 32'(bus.o_State), 0);
    cyc(1, 0, 1, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0, 0);
    chk("dis_risk", 32'(bus.o_Risk), 0);

    // saturation of the bubble counter
    for (int i = 0; i < 10; i++) cyc(1, 1, 1, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0, 0, 0);
    idle();
    chk("sat_cnt", 32'(bus.o_StallCount), SAT);

    // HALT (with a jump that must lose) then drain
    cyc(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1);
    chk("ht_pcw",   32'(bus.o_PC_Write), 0);
    chk("ht_flush", 32'(bus.o_IFID_Flush), 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("dr_halted", 32'(bus.o_Halted), 0);
    end
    idle();
    chk("ht_halted", 32'(bus.o_Halted), 1);
    cyc(1, 1, 1, 1, 5'd4, 5'd4, 5'd0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    idle();
    chk("ht_stay", 32'(bus.o_Halted), 1);

    cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    chk("hrst_halted", 32'(bus.o_Halted), 0);
    idle();
    chk("hrst_pcw", 32'(bus.o_PC_Write), 1);

    // reset abandons a drain
    cyc(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    idle();
    chk("dr_state", 32'(bus.o_State), 2);
    cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    chk("drst_risk",  32'(bus.o_Risk), 1);
    chk("drst_state", 32'(bus.o_State), 0);
    idle();
    chk("post_pcw", 32'(bus.o_PC_Write), 1);
    cyc(1, 1, 1, 1, 5'd8, 5'd0, 5'd8, 1, 0, 0, 0, 0);
    chk("post_risk", 32'(bus.o_Risk), 1);
    idle();
    chk("post_cnt", 32'(bus.o_StallCount), 1);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
